slot_allocator: RTL and testbench
=================================

# slot_allocator

Tracks a pool of NUM_SLOTS resource slots (e.g. miss-queue entries, thread scoreboard entries) and hands out one free slot per cycle, returning its binary index and its one-hot mask in either bit order. It is the stateful successor to a plain index-to-one-hot encoder. Requesters take the current offer with a single-cycle request. Completers return slots by binary index. It sits between a pipeline stage that needs an entry tag and the structure that owns the entries.

## Interface
Parameters:
- NUM_SLOTS, default 8, number of slots; any value ≥ 2, need not be a power of two.
- DIRECTION, default "LSB0", one-hot bit order. "LSB0" maps index 0 to bit 0. "MSB0" maps index 0 to bit NUM_SLOTS-1.
- INDEX_WIDTH, default $clog2(NUM_SLOTS), index width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- alloc_avail  out  1  at least one slot is free; the offer below is valid.
- alloc_idx  out  INDEX_WIDTH  index of the offered slot.
- alloc_oh  out  NUM_SLOTS  one-hot of the offered slot, ordered per DIRECTION.
- alloc_req  in  1  take the offered slot this cycle.
- alloc_gnt  out  1  alloc_req && alloc_avail; allocation commits at this edge.
- free_en  in  1  return slot free_idx.
- free_idx  in  INDEX_WIDTH  index of the slot being returned.
- free_err  out  1  registered pulse: the previous cycle's free targeted an already-free slot, or free_idx ≥ NUM_SLOTS.
- free_count  out  INDEX_WIDTH+1  number of free slots.
- all_free  out  1  free_count == NUM_SLOTS.
- none_free  out  1  free_count == 0.

## Operation
- State:
  - free_mask[NUM_SLOTS], index order, bit i = slot i is free.
  - free_count register.
  - Round-robin pointer, present only with the macro.
- Reset:
  - free_mask all ones and free_count = NUM_SLOTS.
  - Pointer = 0 and free_err = 0.
  - Outputs after reset: alloc_avail=1, alloc_idx=0, alloc_oh has only the bit for index 0 set (bit 0 for LSB0, bit NUM_SLOTS-1 for MSB0), all_free=1, none_free=0.
- Offer:
  - alloc_idx is selected from free_mask by the search policy (see Configuration).
  - alloc_oh is the one-hot encoding of alloc_idx under DIRECTION.
  - When alloc_avail=0, alloc_idx=0 and alloc_oh=0.
- Allocate: on alloc_gnt, clear free_mask[alloc_idx]. alloc_req with alloc_avail=0 is ignored; there is no queuing.
- Free:
  - If free_en and free_idx is in range and free_mask[free_idx]=0, set the bit.
  - Otherwise the state is unchanged and free_err=1 next cycle.
- Simultaneous alloc and free:
  - Both apply at the same edge.
  - The offer is always computed from the pre-edge mask, so a slot freed this cycle is offerable next cycle at the earliest.
  - A free of the slot currently offered cannot occur, because that slot is already free; it is flagged as an error.
- Count: free_count_next = free_count − alloc_gnt + (valid free). It never underflows or overflows.
- Reset mid-operation discards all outstanding allocations; slots freed afterward are reported via free_err.

## Timing
- alloc_avail, alloc_idx, alloc_oh: combinational from registered state only, with no input-to-output path. They are valid the same cycle.
- alloc_gnt: combinational from alloc_req and alloc_avail.
- Allocation and free take effect at the next rising edge. The updated offer, count and flags are visible the cycle after.
- free_err: one cycle after the offending free_en.
- Throughput: one allocation plus one free per cycle, sustained.

## Configuration
- SLOT_ALLOCATOR_ROUND_ROBIN_EN.
- Undefined: fixed priority. The offer is the lowest-index free slot. No pointer register.
- Defined: round robin.
  - The search starts at the pointer and wraps modulo NUM_SLOTS.
  - On alloc_gnt, the pointer becomes alloc_idx+1, wrapping to 0 after NUM_SLOTS-1.
  - The pointer is unchanged by frees and by cycles without a grant.

## Structure
- Shared defines package holds:
  - the "LSB0"/"MSB0" direction string constants;
  - a typedef for the slot-count type, INDEX_WIDTH+1 bits wide.
- One sub-module, slot_search: combinational.
  - Takes free_mask and the start pointer (tied to 0 in priority mode).
  - Returns found and idx.
- Index-to-one-hot conversion for alloc_oh is done inline.

## Test plan
- Reset, then alloc_req held high for 9 cycles, NUM_SLOTS=8, LSB0, priority mode:
  - grants idx 0..7 with alloc_oh 0x01..0x80;
  - in the 9th cycle alloc_avail=0 and alloc_gnt=0;
  - none_free=1 and free_count=0.
- Same sequence with DIRECTION="MSB0": idx 0 gives alloc_oh 0x80 and idx 7 gives 0x01.
- Full pool:
  - free 5 then free 2 on consecutive cycles: priority mode offers 2;
  - with the round-robin macro the pointer has wrapped to 0, so the search from 0 finds 2 first; both modes offer 2;
  - then free 6 in round-robin mode: with the pointer at 3 after allocating 2, the offer is 5.
- Same-cycle allocate of offered slot 3 and free of slot 1:
  - slot 3 is granted;
  - next cycle the offer is 1 and free_count is unchanged.
- Double free of slot 4 while it is free: free_err=1 for exactly one cycle and free_count is unchanged.
- free_idx=7 with NUM_SLOTS=6: free_err=1. Reset asserted with 3 slots allocated: next cycle all_free=1 and free_count=6.

Source files
------------

// File: rtl/slot_allocator_pkg.sv
// Shared definitions for the slot allocator: one-hot direction tags and
// the default-configuration slot-count type.
package slot_allocator_pkg;

  localparam logic [31:0] DIR_LSB0 = "LSB0";
  localparam logic [31:0] DIR_MSB0 = "MSB0";

  localparam int unsigned DEFAULT_NUM_SLOTS = 8;

  // Count of slots in the default configuration (INDEX_WIDTH+1 bits)
  typedef logic [$clog2(DEFAULT_NUM_SLOTS):0] slot_count_t;

endpackage

// File: rtl/slot_allocator_slot_search.sv
// Combinational circular search: first set bit of mask at or after start,
// wrapping modulo NUM_SLOTS. idx is 0 when nothing is found.
module slot_search #(
  parameter int unsigned NUM_SLOTS   = 8,
  parameter int unsigned INDEX_WIDTH = $clog2(NUM_SLOTS)
) (
  input  logic [NUM_SLOTS-1:0]   mask,
  input  logic [INDEX_WIDTH-1:0] start,
  output logic                   found,
  output logic [INDEX_WIDTH-1:0] idx
);

  int unsigned cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
      cand = 32'(start) + k;
      if (cand >= NUM_SLOTS) cand = cand - NUM_SLOTS;
      if (!found && mask[cand[INDEX_WIDTH-1:0]]) begin
        found = 1'b1;
        idx   = cand[INDEX_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/slot_allocator.sv
// Free-slot pool: offers one free slot per cycle (index + one-hot) and
// accepts one returned slot per cycle. SLOT_ALLOCATOR_ROUND_ROBIN_EN selects
// round-robin search instead of lowest-index priority.
module slot_allocator
  import slot_allocator_pkg::*;
#(
  parameter int unsigned NUM_SLOTS   = 8,
  parameter logic [31:0] DIRECTION   = "LSB0",
  parameter int unsigned INDEX_WIDTH = $clog2(NUM_SLOTS)
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   alloc_avail,
  output logic [INDEX_WIDTH-1:0] alloc_idx,
  output logic [NUM_SLOTS-1:0]   alloc_oh,
  input  logic                   alloc_req,
  output logic                   alloc_gnt,
  input  logic                   free_en,
  input  logic [INDEX_WIDTH-1:0] free_idx,
  output logic                   free_err,
  output logic [INDEX_WIDTH:0]   free_count,
  output logic                   all_free,
  output logic                   none_free
);

  typedef logic [INDEX_WIDTH:0] count_t;

  localparam bit MSB_FIRST = (DIRECTION == DIR_MSB0);

  logic [NUM_SLOTS-1:0]   free_mask;
  logic [NUM_SLOTS-1:0]   mask_next;
  logic [INDEX_WIDTH-1:0] search_start;
  logic                   free_hit;
  logic                   free_valid;

`ifdef SLOT_ALLOCATOR_ROUND_ROBIN_EN
  logic [INDEX_WIDTH-1:0] ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (alloc_gnt) begin
      ptr <= (alloc_idx == INDEX_WIDTH'(NUM_SLOTS - 1)) ? '0 : alloc_idx + INDEX_WIDTH'(1);
    end
  end

  assign search_start = ptr;
`else
  assign search_start = '0;
`endif

  slot_search #(
    .NUM_SLOTS   (NUM_SLOTS),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_search (
    .mask  (free_mask),
    .start (search_start),
    .found (alloc_avail),
    .idx   (alloc_idx)
  );

  assign alloc_gnt = alloc_req && alloc_avail;
  assign all_free  = (free_count == count_t'(NUM_SLOTS));
  assign none_free = (free_count == '0);

  always_comb begin
    alloc_oh = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      alloc_oh[i] = alloc_avail &&
                    (alloc_idx == INDEX_WIDTH'(MSB_FIRST ? NUM_SLOTS - 1 - i : i));
    end
  end

  // Out-of-range free_idx never matches a decoded slot, so it falls out as an error
  always_comb begin
    free_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (free_idx == INDEX_WIDTH'(i)) free_hit = !free_mask[i];
    end
    free_valid = free_en && free_hit;
    mask_next  = free_mask;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (alloc_gnt && alloc_idx == INDEX_WIDTH'(i)) mask_next[i] = 1'b0;
      if (free_valid && free_idx == INDEX_WIDTH'(i)) mask_next[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      free_mask  <= '1;
      free_count <= count_t'(NUM_SLOTS);
      free_err   <= 1'b0;
    end else begin
      free_mask  <= mask_next;
      free_count <= free_count - count_t'(alloc_gnt) + count_t'(free_valid);
      free_err   <= free_en && !free_valid;
    end
  end

endmodule

// File: tb/tb_slot_allocator.sv
// Self-checking bench: three allocator instances (8 LSB0, 8 MSB0, 6 LSB0)
// against a behavioural pool model, plus directed corner sequences.
module tb_slot_allocator;

`ifdef SLOT_ALLOCATOR_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       req_ab, fen_ab, req_c, fen_c;
  logic [2:0] fidx_ab, fidx_c;

  logic       a_avail, a_gnt, a_err, a_all, a_none;
  logic [2:0] a_idx;
  logic [7:0] a_oh;
  logic [3:0] a_count;
  logic       b_avail, b_gnt, b_err, b_all, b_none;
  logic [2:0] b_idx;
  logic [7:0] b_oh;
  logic [3:0] b_count;
  logic       c_avail, c_gnt, c_err, c_all, c_none;
  logic [2:0] c_idx;
  logic [5:0] c_oh;
  logic [3:0] c_count;

  slot_allocator #(.NUM_SLOTS(8), .DIRECTION("LSB0")) dut_a (
    .clk(clk), .reset(reset), .alloc_avail(a_avail), .alloc_idx(a_idx), .alloc_oh(a_oh),
    .alloc_req(req_ab), .alloc_gnt(a_gnt), .free_en(fen_ab), .free_idx(fidx_ab),
    .free_err(a_err), .free_count(a_count), .all_free(a_all), .none_free(a_none));

  slot_allocator #(.NUM_SLOTS(8), .DIRECTION("MSB0")) dut_b (
    .clk(clk), .reset(reset), .alloc_avail(b_avail), .alloc_idx(b_idx), .alloc_oh(b_oh),
    .alloc_req(req_ab), .alloc_gnt(b_gnt), .free_en(fen_ab), .free_idx(fidx_ab),
    .free_err(b_err), .free_count(b_count), .all_free(b_all), .none_free(b_none));

  slot_allocator #(.NUM_SLOTS(6), .DIRECTION("LSB0")) dut_c (
    .clk(clk), .reset(reset), .alloc_avail(c_avail), .alloc_idx(c_idx), .alloc_oh(c_oh),
    .alloc_req(req_c), .alloc_gnt(c_gnt), .free_en(fen_c), .free_idx(fidx_c),
    .free_err(c_err), .free_count(c_count), .all_free(c_all), .none_free(c_none));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Model: m=0 tracks the two 8-slot instances, m=1 the 6-slot instance
  bit mfree[2][8];
  int mptr[2];
  bit merr[2];

  function automatic int nslots(input int m);
    return (m == 0) ? 8 : 6;
  endfunction

  function automatic int mcount(input int m);
    int c = 0;
    for (int j = 0; j < 8; j++) c += int'(mfree[m][j]);
    return c;
  endfunction

  function automatic void moffer(input int m, output bit f, output int idx);
    int n = nslots(m);
    int s = RR ? mptr[m] : 0;
    f = 1'b0;
    idx = 0;
    for (int k = 0; k < n; k++) begin
      if (!f && mfree[m][(s + k) % n]) begin
        f = 1'b1;
        idx = (s + k) % n;
      end
    end
  endfunction

  function automatic void mupdate(input int m, input bit rst, input bit req,
                                  input bit fen, input int fidx);
    int n = nslots(m);
    bit f;
    int idx;
    bit valid;
    moffer(m, f, idx);
    valid = fen && (fidx < n) && !mfree[m][fidx];
    if (rst) begin
      for (int j = 0; j < 8; j++) mfree[m][j] = (j < n);
      mptr[m] = 0;
      merr[m] = 1'b0;
    end else begin
      merr[m] = fen && !valid;
      if (req && f) begin
        mfree[m][idx] = 1'b0;
        mptr[m] = (idx + 1) % n;
      end
      if (valid) mfree[m][fidx] = 1'b1;
    end
  endfunction

  task automatic advance();
    @(posedge clk);
    mupdate(0, reset, req_ab, fen_ab, int'(fidx_ab));
    mupdate(1, reset, req_c, fen_c, int'(fidx_c));
    #1;
  endtask

  task automatic check_all();
    bit f;
    int idx, cnt;
    moffer(0, f, idx);
    cnt = mcount(0);
    chk("a_avail", 32'(a_avail), 32'(f));
    chk("a_idx", 32'(a_idx), f ? idx : 0);
    chk("a_oh", 32'(a_oh), f ? (1 << idx) : 0);
    chk("a_gnt", 32'(a_gnt), 32'(req_ab && f));
    chk("a_err", 32'(a_err), 32'(merr[0]));
    chk("a_count", 32'(a_count), cnt);
    chk("a_all", 32'(a_all), 32'(cnt == 8));
    chk("a_none", 32'(a_none), 32'(cnt == 0));
    chk("b_idx", 32'(b_idx), f ? idx : 0);
    chk("b_oh", 32'(b_oh), f ? (1 << (7 - idx)) : 0);
    chk("b_err", 32'(b_err), 32'(merr[0]));
    chk("b_count", 32'(b_count), cnt);
    moffer(1, f, idx);
    cnt = mcount(1);
    chk("c_avail", 32'(c_avail), 32'(f));
    chk("c_idx", 32'(c_idx), f ? idx : 0);
    chk("c_oh", 32'(c_oh), f ? (1 << idx) : 0);
    chk("c_gnt", 32'(c_gnt), 32'(req_c && f));
    chk("c_err", 32'(c_err), 32'(merr[1]));
    chk("c_count", 32'(c_count), cnt);
    chk("c_all", 32'(c_all), 32'(cnt == 6));
    chk("c_none", 32'(c_none), 32'(cnt == 0));
  endtask

  typedef struct {
    bit req;
    bit avail;
    int idx;
    int oh_lsb;
    int oh_msb;
    bit gnt;
    int cnt;
  } vec_t;

  vec_t tv[9];

  initial begin
    for (int i = 0; i < 8; i++) tv[i] = '{1'b1, 1'b1, i, 1 << i, 8'h80 >> i, 1'b1, 8 - i};
    tv[8] = '{1'b1, 1'b0, 0, 0, 0, 1'b0, 0};

    reset = 1'b1;
    req_ab = 1'b0; fen_ab = 1'b0; fidx_ab = '0;
    req_c = 1'b0; fen_c = 1'b0; fidx_c = '0;
    mupdate(0, 1'b1, 1'b0, 1'b0, 0);
    mupdate(1, 1'b1, 1'b0, 1'b0, 0);
    advance();
    advance();
    reset = 1'b0;
    #1;
    chk("rst_a_oh", 32'(a_oh), 32'h01);
    chk("rst_b_oh", 32'(b_oh), 32'h80);
    chk("rst_c_count", 32'(c_count), 6);
    check_all();

    // Drain the 8-slot pool one grant per cycle
    for (int i = 0; i < 9; i++) begin
      req_ab = tv[i].req;
      #1;
      chk("tv_avail", 32'(a_avail), 32'(tv[i].avail));
      chk("tv_idx", 32'(a_idx), tv[i].idx);
      chk("tv_oh_lsb", 32'(a_oh), tv[i].oh_lsb);
      chk("tv_oh_msb", 32'(b_oh), tv[i].oh_msb);
      chk("tv_gnt", 32'(a_gnt), 32'(tv[i].gnt));
      chk("tv_count", 32'(a_count), tv[i].cnt);
      advance();
    end
    req_ab = 1'b0;
    #1;
    chk("drain_none", 32'(a_none), 1);
    chk("drain_count", 32'(a_count), 0);

    // Full pool: free 5 then 2, offer 2; take it, free 6, offer 5
    fen_ab = 1'b1; fidx_ab = 3'd5;
    advance();
    fidx_ab = 3'd2;
    advance();
    fen_ab = 1'b0;
    #1;
    chk("full_offer2", 32'(a_idx), 2);
    chk("full_offer2_msb", 32'(b_oh), 32'h20);
    chk("full_count2", 32'(a_count), 2);
    req_ab = 1'b1;
    advance();
    req_ab = 1'b0; fen_ab = 1'b1; fidx_ab = 3'd6;
    advance();
    fen_ab = 1'b0;
    #1;
    chk("full_offer5", 32'(a_idx), 5);
    chk("full_count", 32'(a_count), 2);

    // Same-cycle grant of slot 3 and free of slot 1
    reset = 1'b1;
    advance();
    reset = 1'b0;
    req_ab = 1'b1;
    advance(); advance(); advance();
    fen_ab = 1'b1; fidx_ab = 3'd1;
    #1;
    chk("same_gnt", 32'(a_gnt), 1);
    chk("same_idx", 32'(a_idx), 3);
    chk("same_count_before", 32'(a_count), 5);
    advance();
    req_ab = 1'b0; fen_ab = 1'b0;
    #1;
    chk("same_next_offer", 32'(a_idx), RR ? 4 : 1);
    chk("same_count_after", 32'(a_count), 5);

    // Double free of already-free slot 4
    fen_ab = 1'b1; fidx_ab = 3'd4;
    #1;
    chk("dbl_err_pre", 32'(a_err), 0);
    advance();
    fen_ab = 1'b0;
    #1;
    chk("dbl_err", 32'(a_err), 1);
    chk("dbl_count", 32'(a_count), 5);
    check_all();
    advance();
    chk("dbl_err_clear", 32'(a_err), 0);

    // 6-slot instance: out-of-range free, then reset with slots allocated
    fen_c = 1'b1; fidx_c = 3'd7;
    advance();
    fen_c = 1'b0;
    #1;
    chk("c_range_err", 32'(c_err), 1);
    req_c = 1'b1;
    advance(); advance(); advance();
    req_c = 1'b0;
    #1;
    chk("c_alloc3_count", 32'(c_count), 3);
    chk("c_alloc3_idx", 32'(c_idx), 3);
    reset = 1'b1;
    advance();
    reset = 1'b0;
    #1;
    chk("c_rst_all", 32'(c_all), 1);
    chk("c_rst_count", 32'(c_count), 6);
    fen_c = 1'b1; fidx_c = 3'd0;
    advance();
    fen_c = 1'b0;
    #1;
    chk("c_stale_free_err", 32'(c_err), 1);
    check_all();

    // Random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      reset   = ($urandom_range(0, 99) == 0);
      req_ab  = ($urandom_range(0, 3) != 0);
      fen_ab  = ($urandom_range(0, 1) == 1);
      fidx_ab = 3'($urandom_range(0, 7));
      req_c   = ($urandom_range(0, 2) != 0);
      fen_c   = ($urandom_range(0, 1) == 1);
      fidx_c  = 3'($urandom_range(0, 7));
      #1;
      check_all();
      advance();
    end
    reset = 1'b0;
    req_ab = 1'b0; fen_ab = 1'b0; req_c = 1'b0; fen_c = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
